// File: rtl/slt_32.sv
// slt_32 -- set-less-than comparator for the RV32 ALU result mux.
// Computes x1 - x2 with a carry-lookahead subtractor and derives the
// signed (N ^ V) or unsigned (~C) less-than flag. Only bit 0 of the
// result can be set.
// Optional build macro: SLT_32_REG_OUT_EN adds a 1-cycle output register
// on clk, with a synchronous active-low reset to 0.

// 4-bit carry-lookahead adder slice. Its carries come from the group's
// generate/propagate terms, so they do not ripple bit to bit inside the group.
module slt_32_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, fully expanded from ci.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;
endmodule

module slt_32 #(
    parameter int SIGNED = 1,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] out
);
    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] nx2;    // ~x2; the +1 enters as the carry-in of group 0
    logic [WIDTH-1:0] d;      // x1 - x2
    logic [NGRP:0]    gc;     // carries rippling between the 4-bit groups
    logic             c_flag;
    logic             n_flag;
    logic             v_flag;
    logic             lt;
    logic [WIDTH-1:0] res;

    assign nx2   = ~x2;
    assign gc[0] = 1'b1;

    // Subtractor: lookahead inside each group, ripple from group to group.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        slt_32_cla4 u_cla4 (
            .a  (x1[4*gi +: 4]),
            .b  (nx2[4*gi +: 4]),
            .ci (gc[gi]),
            .s  (d[4*gi +: 4]),
            .co (gc[gi+1])
        );
    end

    // A borrow-free subtract (C = 1) means x1 >= x2 as unsigned numbers.
    // Signed overflow is only possible when the operand signs differ.
    assign c_flag = gc[NGRP];
    assign n_flag = d[WIDTH-1];
    assign v_flag = (x1[WIDTH-1] ^ x2[WIDTH-1]) & (n_flag ^ x1[WIDTH-1]);
    assign lt     = (SIGNED != 0) ? (n_flag ^ v_flag) : ~c_flag;
    assign res    = {{(WIDTH-1){1'b0}}, lt};

    // Only the sign bit of the difference feeds the flags.
    logic unused_d;
    assign unused_d = &{1'b0, d[WIDTH-2:0]};

`ifdef SLT_32_REG_OUT_EN
    logic [WIDTH-1:0] out_q;

    // Output register; a low rst_n at the edge discards the in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= res;
    end

    assign out = out_q;
`else
    // Combinational build: clk and rst_n exist only to keep the port list stable.
    logic unused_clk;
    assign unused_clk = &{1'b0, clk, rst_n};

    assign out = res;
`endif
endmodule

// File: tb/tb_slt_32.sv
// tb_slt_32 -- directed and random checks of slt_32 in both SIGNED modes.
// When compiled with SLT_32_REG_OUT_EN, it also checks reset and latency.
module tb_slt_32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] out_s;
    logic [31:0] out_u;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    slt_32 #(.SIGNED(1), .WIDTH(32)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .out(out_s)
    );

    slt_32 #(.SIGNED(0), .WIDTH(32)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .out(out_u)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a vector and wait until the result is observable.
    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        x1 = a;
        x2 = b;
`ifdef SLT_32_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #5;
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        ref_s;
        logic        ref_u;

        x1    = 32'd1;
        x2    = 32'd2;
        rst_n = 1'b0;

`ifdef SLT_32_REG_OUT_EN
        // Hold reset for two edges. The result must stay 0 even though 1 < 2.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_s", out_s, 32'd0);
        check("rst_u", out_u, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_s", out_s, 32'd1);
        check("rel_u", out_u, 32'd1);
        // Between edges, an input change is not visible yet.
        x1 = 32'd2;
        x2 = 32'd1;
        #2;
        check("hold_s", out_s, 32'd1);
        @(posedge clk);
        #1;
        check("upd_s", out_s, 32'd0);
        // Reset mid-stream discards the pending true result.
        x1 = 32'd1;
        x2 = 32'd2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_s", out_s, 32'd0);
        rst_n = 1'b1;
`else
        rst_n = 1'b1;
`endif

        // Basic signed vectors.
        apply(32'd10, 32'd20);               check("s_10_20", out_s, 32'd1);
        apply(32'd15, 32'd15);               check("s_eq", out_s, 32'd0);
                                             check("u_eq", out_u, 32'd0);
        apply(32'd25, 32'd5);                check("s_25_5", out_s, 32'd0);
        // Boundaries: signed vs unsigned.
        apply(32'h0000_0000, 32'hFFFF_FFFF); check("s_0_m1", out_s, 32'd0);
                                             check("u_0_max", out_u, 32'd1);
        apply(32'hFFFF_FFFF, 32'h0000_0000); check("s_m1_0", out_s, 32'd1);
                                             check("u_max_0", out_u, 32'd0);
        apply(32'h8000_0000, 32'h7FFF_FFFF); check("s_min_max", out_s, 32'd1);
                                             check("u_8_7", out_u, 32'd0);
        apply(32'h7FFF_FFFF, 32'h8000_0000); check("s_max_min", out_s, 32'd0);
                                             check("u_7_8", out_u, 32'd1);
        apply(32'h8000_0000, 32'h8000_0000); check("s_min_eq", out_s, 32'd0);
                                             check("u_min_eq", out_u, 32'd0);

        // Random sweep checked against the language's compare. Every 8th
        // pair uses equal operands, and every 8th+1 pair differs only in the sign bit.
        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) b = a;
            if (i % 8 == 1) b = a ^ 32'h8000_0000;
            ref_s = ($signed(a) < $signed(b));
            ref_u = (a < b);
            apply(a, b);
            check("rnd_s", out_s, {31'd0, ref_s});
            check("rnd_u", out_u, {31'd0, ref_u});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/slt_32.md
# slt_32

Set-less-than comparator for the RV32 ALU. Compares two 32-bit operands and returns 32'd1 when x1 < x2, else 32'd0. By default x1 and x2 are compared as two's-complement values (SLT/SLTI); a parameter selects the unsigned comparison (SLTU/SLTIU). It sits in the ALU result mux alongside the adder, shifter and logic units.

## Interface
- Parameters:
- SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned compare.
- WIDTH, default 32: operand and result width. Only 32 is supported in the RV32 datapath.
- Ports:
- clk  input  1  datapath clock. Used only when SLT_32_REG_OUT_EN is defined.
- rst_n  input  1  reset, synchronous and active-low. Used only when SLT_32_REG_OUT_EN is defined.
- x1  input  WIDTH  left operand (rs1).
- x2  input  WIDTH  right operand (rs2 or immediate).
- out  output  WIDTH  comparison result. Bit 0 = (x1 < x2); bits WIDTH-1..1 are always 0.

## Operation
- The comparison is computed by subtraction: d = x1 + ~x2 + 1, with carry-out C, sign N = d[WIDTH-1], and overflow V = (x1[msb] != x2[msb]) && (N != x1[msb]).
- The subtractor uses 4-bit carry-lookahead groups with a ripple between groups. It must not use a behavioural `<` on the full operands.
- Result selection:
  - SIGNED=1: lt = N ^ V.
  - SIGNED=0: lt = ~C.
- When x1 == x2, lt = 0 in both modes.
- Signed boundaries:
  - 0x80000000 < 0x7FFFFFFF is true.
  - 0x7FFFFFFF < 0x80000000 is false.
  - 0x00000000 < 0xFFFFFFFF is false, because 0xFFFFFFFF is -1.
  - 0xFFFFFFFF < 0x00000000 is true.
- Unsigned boundaries:
  - 0 < 0xFFFFFFFF is true.
  - 0xFFFFFFFF < 0 is false.
  - 0x80000000 < 0x7FFFFFFF is false.
- out = {{(WIDTH-1){1'b0}}, lt}.
- No X is propagated from unused upper bits. out[WIDTH-1:1] is tied to constant 0.

## Timing
- Default build: purely combinational.
  - out is valid within the same evaluation as x1 and x2 change, with zero cycle latency.
  - clk and rst_n are ignored and may be left unconnected.
  - There is no reset value, because out always follows the inputs.
- With SLT_32_REG_OUT_EN:
  - out is registered on the rising edge of clk, giving 1-cycle latency.
  - When rst_n = 0 at a rising edge, out is 32'd0 after that edge, regardless of x1 and x2.
  - The first valid result appears on the first rising edge with rst_n = 1.
  - Asserting rst_n mid-stream discards the in-flight result; out reads 0 on the next cycle.
  - Input changes between edges are not visible on out until the next edge.
- No handshake. Every cycle, or every input change in the default build, produces a result.

## Configuration
- Macro: SLT_32_REG_OUT_EN.
- Undefined (default): combinational output. The clk/rst_n logic is compiled out.
- Defined: a WIDTH-bit output register is added on clk, with synchronous active-low reset to 0 via rst_n. This gives 1-cycle latency; the compare logic is unchanged.

## Test plan
Default build, SIGNED=1, 5 ns spacing between vectors:
- x1=10, x2=20 -> out=1; x1=15, x2=15 -> out=0; x1=25, x2=5 -> out=0.
- x1=0, x2=0xFFFFFFFF -> out=0; x1=0xFFFFFFFF, x2=0 -> out=1.
- x1=0x80000000, x2=0x7FFFFFFF -> out=1; x1=0x7FFFFFFF, x2=0x80000000 -> out=0.
- SIGNED=0, same vectors as the two lines above:
  - (0, 0xFFFFFFFF) -> 1
  - (0xFFFFFFFF, 0) -> 0
  - (0x80000000, 0x7FFFFFFF) -> 0
  - (0x7FFFFFFF, 0x80000000) -> 1
- SLT_32_REG_OUT_EN: hold rst_n=0 for 2 edges with x1=1, x2=2 -> out=0. Release rst_n -> out=1 one edge later. Change to x1=2, x2=1 -> out stays 1 until the next edge, then reads 0.
- Random sweep of 10,000 vector pairs in both SIGNED modes: out[31:1] is always 0, and out[0] matches the $signed or unsigned `<` reference model.
